burst_mem_responder: RTL and testbench

Memory-side responder for the cache's burst memory interface: accepts single-command burst reads and per-beat burst writes from one initiator and serves them from an internal word-addressed array. Sits at the far end of the cache `mem_*` port, standing in for external memory in simulation and in small on-chip configurations. Provides configurable read latency, address wrap, protocol-error flagging and optional pseudo-random back-pressure.

---
 rtl/burst_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_burst_mem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: memory-side responder for a burst memory port.
// Serves single-command burst reads and per-beat burst writes from an
// internal word-addressed array, with configurable read latency, address
// wrap within the array and a sticky protocol-error flag.
// Optional feature macro: BURST_MEM_STALL_EN adds LFSR-driven back-pressure
// on the request side (IDLE and WR_BURST only).
module burst_mem_responder #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          BURST_WIDTH = 2,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LATENCY  = 2,
  parameter logic [10:0] LFSR_SEED   = 11'd101
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [BURST_WIDTH-1:0] mem_burst_len,
  input  logic                   mem_rd,
  input  logic                   mem_wr,
  input  logic [DATA_WIDTH-1:0]  mem_wr_data,
  output logic                   mem_waitrequest,
  output logic [DATA_WIDTH-1:0]  mem_rd_data,
  output logic                   mem_rd_valid,
  output logic                   mem_err
);

  localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int BEAT_W    = BURST_WIDTH + 1;
  localparam int LAT_W     = $clog2(RD_LATENCY + 1);
  // RD_LAT lasts RD_LATENCY-1 cycles; the counter runs down to zero.
  localparam int LAT_INIT  = (RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RD_LAT   = 2'd1;
  localparam logic [1:0] S_RD_BURST = 2'd2;
  localparam logic [1:0] S_WR_BURST = 2'd3;

  logic [1:0]             r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [BURST_WIDTH-1:0] r_len;
  logic [BEAT_W-1:0]      r_beat;
  logic [BURST_WIDTH-1:0] r_wr_left;
  logic [LAT_W-1:0]       r_lat;
  logic                   r_rd_valid;
  logic [DATA_WIDTH-1:0]  r_rd_data;
  logic                   r_err;
  logic [DATA_WIDTH-1:0]  r_mem [DEPTH_WORDS];

  logic                   w_stall;
  logic                   w_busy;
  logic                   w_accept;
  logic [IDX_W-1:0]       w_addr_idx;
  logic                   w_mem_we;
  logic [IDX_W-1:0]       w_mem_widx;
  logic                   w_proto_err;
  logic                   w_unused_bits;

`ifdef BURST_MEM_STALL_EN
  logic [10:0] r_lfsr;

  // Free-running x^11+x^9+1 LFSR; bit 0 requests a stall on the request side.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[9:0], r_lfsr[10] ^ r_lfsr[8]};
    end
  end

  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  // Low byte-lane bits and address bits above the array index alias away.
  assign w_unused_bits = ^{mem_addr, LFSR_SEED};
  assign w_addr_idx    = mem_addr[BYTE_BITS +: IDX_W];

  // Read phases always block new requests; stalls only apply elsewhere.
  assign w_busy          = (r_state == S_RD_LAT) || (r_state == S_RD_BURST);
  assign mem_waitrequest = !reset_n || w_busy || w_stall;
  assign w_accept        = !mem_waitrequest;

  // A write beat lands when accepted in IDLE (unless it collides with a
  // read, which wins) or in WR_BURST, where the running index is used.
  assign w_mem_we   = w_accept && mem_wr &&
                      (((r_state == S_IDLE) && !mem_rd) || (r_state == S_WR_BURST));
  assign w_mem_widx = (r_state == S_IDLE) ? w_addr_idx : r_idx;

  assign w_proto_err = ((r_state == S_IDLE) && mem_rd && mem_wr) ||
                       ((r_state == S_WR_BURST) && mem_rd) ||
                       (w_busy && mem_wr);

  // Storage array: never reset, so accepted beats survive a mid-burst reset.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_widx] <= mem_wr_data;
    end
  end

  // Main control FSM plus the registered read-beat outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_wr_left  <= '0;
      r_lat      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && mem_rd) begin
            r_idx  <= w_addr_idx;
            r_len  <= mem_burst_len;
            r_beat <= '0;
            r_lat  <= LAT_W'(LAT_INIT);
            r_state <= (RD_LATENCY > 1) ? S_RD_LAT : S_RD_BURST;
          end else if (w_accept && mem_wr) begin
            if (mem_burst_len != '0) begin
              r_idx     <= w_addr_idx + IDX_W'(1);
              r_wr_left <= mem_burst_len;
              r_state   <= S_WR_BURST;
            end
          end
        end
        S_RD_LAT: begin
          if (r_lat == '0) begin
            r_state <= S_RD_BURST;
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        S_RD_BURST: begin
          // One beat per edge; the extra final edge retires the last beat
          // so waitrequest covers the whole last-beat cycle.
          if (r_beat <= {1'b0, r_len}) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= r_mem[r_idx];
            r_idx      <= r_idx + IDX_W'(1);
            r_beat     <= r_beat + BEAT_W'(1);
          end else begin
            r_rd_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_WR_BURST: begin
          if (w_accept && mem_wr) begin
            r_idx     <= r_idx + IDX_W'(1);
            r_wr_left <= r_wr_left - BURST_WIDTH'(1);
            if (r_wr_left == BURST_WIDTH'(1)) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_proto_err) begin
      r_err <= 1'b1;
    end
  end

  assign mem_rd_valid = r_rd_valid;
  assign mem_rd_data  = r_rd_data;
  assign mem_err      = r_err;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed + randomized bench for burst_mem_responder with a word-array
// reference model; inputs driven and outputs sampled on the falling edge.
module tb_burst_mem_responder;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 2;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [BW-1:0] mem_burst_len = '0;
  logic          mem_rd = 1'b0;
  logic          mem_wr = 1'b0;
  logic [DW-1:0] mem_wr_data = '0;
  logic          mem_waitrequest;
  logic [DW-1:0] mem_rd_data;
  logic          mem_rd_valid;
  logic          mem_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] model [DEPTH];
  bit          written [DEPTH];
  logic [31:0] wbuf [4];

  burst_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW),
    .DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT), .LFSR_SEED(11'd101)
  ) dut (
    .clock(clock), .reset_n(reset_n), .mem_addr(mem_addr),
    .mem_burst_len(mem_burst_len), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wr_data(mem_wr_data), .mem_waitrequest(mem_waitrequest),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .mem_err(mem_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) until the next rising edge will accept a request.
  task automatic wait_ready(input string tag);
    int g;
    g = 0;
    while (mem_waitrequest !== 1'b0 && g < 200) begin
      @(negedge clock);
      g++;
    end
    chk({tag, "_ready"}, 32'(mem_waitrequest), 32'(0));
  endtask

  // Writes len+1 beats from wbuf; bub_n idle cycles after beat bub_after.
  task automatic do_write(input logic [31:0] addr, input int len,
                          input int bub_after, input int bub_n);
    int base;
    base = word_of(addr);
    for (int k = 0; k <= len; k++) begin
      mem_wr = 1'b1;
      mem_wr_data = wbuf[k];
      if (k == 0) begin
        mem_addr = addr;
        mem_burst_len = BW'(len);
      end else begin
        mem_addr = $urandom;
        mem_burst_len = BW'($urandom);
      end
      wait_ready("wr");
      @(negedge clock);
      model[(base + k) % DEPTH] = wbuf[k];
      written[(base + k) % DEPTH] = 1'b1;
      mem_wr = 1'b0;
      if (k == bub_after) repeat (bub_n) @(negedge clock);
    end
  endtask

  // Issues a read (optionally with mem_wr also high) and checks beat timing,
  // waitrequest coverage and data against the model.
  task automatic do_read(input logic [31:0] addr, input int len,
                         input logic both, input logic [31:0] wdata);
    int base, t, k, last;
    logic expv;
    base = word_of(addr);
    mem_addr = addr;
    mem_burst_len = BW'(len);
    mem_rd = 1'b1;
    mem_wr = both;
    mem_wr_data = wdata;
    wait_ready("rd");
    t = cyc + 1;
    @(negedge clock);
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    mem_addr = $urandom;
    k = 0;
    last = -1;
    while (cyc <= t + LAT + len + 1) begin
      expv = (cyc >= t + LAT) && (cyc <= t + LAT + len);
      chk("rd_valid", 32'(mem_rd_valid), 32'(expv));
      if (cyc <= t + LAT + len) chk("rd_wait", 32'(mem_waitrequest), 32'(1));
      if (expv) begin
        last = (base + k) % DEPTH;
        if (written[last]) chk("rd_data", mem_rd_data, model[last]);
        k++;
      end
      @(negedge clock);
    end
    if (last >= 0 && written[last]) chk("rd_hold", mem_rd_data, model[last]);
  endtask

  initial begin
    int t, ra, rl;
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_wait", 32'(mem_waitrequest), 32'(1));
    chk("rst_valid", 32'(mem_rd_valid), 32'(0));
    chk("rst_data", mem_rd_data, 32'(0));
    chk("rst_err", 32'(mem_err), 32'(0));
    reset_n = 1'b1;
    @(negedge clock);

    // Write burst then read burst
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hA0 + 32'(k);
    do_write(32'h40, 3, -1, 0);
    do_read(32'h40, 3, 1'b0, 32'h0);

    // Wrap at the top of the array, single-beat reads with aliasing/low bits
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hC0DE_0000 + 32'(k);
    do_write(32'(1022 * 4), 3, -1, 0);
    do_read(32'(1022 * 4) | 32'h0001_0000, 0, 1'b0, 32'h0);
    do_read(32'(1023 * 4) + 32'd3, 0, 1'b0, 32'h0);
    do_read(32'h0, 0, 1'b0, 32'h0);
    do_read(32'h8000_0004, 0, 1'b0, 32'h0);
    do_read(32'(1022 * 4), 3, 1'b0, 32'h0);

    // Write bubbles between beats 1 and 2
    for (int k = 0; k < 4; k++) wbuf[k] = 32'h5B00 + 32'(k);
    do_write(32'h200, 3, 1, 2);
    chk("bubble_err", 32'(mem_err), 32'(0));
    do_read(32'h200, 3, 1'b0, 32'h0);

    // Protocol error: read and write together in IDLE
    wbuf[0] = 32'h1234_5678;
    do_write(32'h0, 0, -1, 0);
    chk("pre_err", 32'(mem_err), 32'(0));
    do_read(32'h0, 0, 1'b1, 32'hDEAD_BEEF);
    chk("proto_err", 32'(mem_err), 32'(1));
    do_read(32'h0, 1, 1'b0, 32'h0);
    chk("proto_err_sticky", 32'(mem_err), 32'(1));

    // Reset during read beat 1 of 4
    mem_addr = 32'h40;
    mem_burst_len = 2'd3;
    mem_rd = 1'b1;
    wait_ready("rst_rd");
    t = cyc + 1;
    @(negedge clock);
    mem_rd = 1'b0;
    while (cyc < t + LAT + 1) @(negedge clock);
    chk("mid_beat1_valid", 32'(mem_rd_valid), 32'(1));
    chk("mid_beat1_data", mem_rd_data, model[word_of(32'h40) + 1]);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mid_rst_valid", 32'(mem_rd_valid), 32'(0));
    chk("mid_rst_data", mem_rd_data, 32'(0));
    chk("mid_rst_wait", 32'(mem_waitrequest), 32'(1));
    chk("mid_rst_err", 32'(mem_err), 32'(0));
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      chk("post_rst_valid", 32'(mem_rd_valid), 32'(0));
    end
    do_read(32'h40, 3, 1'b0, 32'h0);

    // Randomized bursts against the model
    for (int n = 0; n < 40; n++) begin
      ra = int'($urandom);
      rl = int'($urandom_range(3, 0));
      for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
      do_write(32'(ra), rl, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
      do_read(32'(ra), int'($urandom_range(3, 0)), 1'b0, 32'h0);
    end
    chk("final_err", 32'(mem_err), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
